// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the UART transmitter and receiver: the common
//   baud divisor, the data width and the receiver state encoding.
//   No ports.
package uart_pkg;

  // Clock cycles per bit at 115200 baud from the 133.33 MHz system clock.
  localparam int B115K2 = 1157;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
//   Brings the asynchronous receive pin into the clock domain through two
//   flops and flags a synchronized high-to-low transition.
// Ports
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset; every flop resets to the idle level 1
//   rxd   : raw serial pin
//   rxd_s : synchronized line level
//   fall  : high for one cycle when rxd_s goes from 1 to 0
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  logic meta;
  logic prev;

  // Two-stage synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b1;
      rxd_s <= 1'b1;
      prev  <= 1'b1;
    end else begin
      meta  <= rxd;
      rxd_s <= meta;
      prev  <= rxd_s;
    end
  end

  assign fall = prev & ~rxd_s;

endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   8N1 UART receiver. Deserialises uart_rxd into bytes held in a one-entry
//   buffer drained over a valid/ready handshake. Framing errors and dropped
//   bytes are reported as one-cycle pulses.
// Ports
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   uart_rxd    : asynchronous serial input, idles high
//   o_data      : received byte, stable while o_valid is high
//   o_valid     : buffer holds an unconsumed byte
//   i_ready     : consumer accepts the byte when o_valid is also high
//   o_frame_err : pulse when the stop bit samples 0
//   o_overrun   : pulse when a good byte is dropped because the buffer is full
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_DIV = B115K2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   uart_rxd,
  output logic [UART_DATA_W-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_frame_err,
  output logic                   o_overrun
);

  localparam int BIT_W = $clog2(UART_DATA_W);
  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_W - 1);
  // Cycles the synchronizer needs to flush its reset value of 1.
  localparam logic [15:0] SETTLE = 16'd2;

  logic rxd_s;
  logic fall;

  rx_state_t state;
  logic [15:0] cnt;
  logic [BIT_W-1:0] bit_idx;
  logic [UART_DATA_W-1:0] shift;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .rxd  (uart_rxd),
    .rxd_s(rxd_s),
    .fall (fall)
  );

  // Receive FSM, bit timing counter, shift register and the output buffer.
  // A transfer clears o_valid by default; a byte completing in the same
  // cycle overrides that clear further down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_HIGH;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      case (state)
        // The synchronizer still shows its reset value of 1 for a couple of
        // cycles after reset, so let it settle before trusting a high line;
        // otherwise releasing reset mid-frame would look like a fresh start.
        WAIT_HIGH: begin
          if (cnt < SETTLE) begin
            cnt <= cnt + 16'd1;
          end else if (rxd_s) begin
            state <= IDLE;
          end
        end

        IDLE: begin
          if (fall) begin
            state <= START;
            cnt   <= '0;
          end
        end

        // Mid-start-bit check rejects short glitches.
        START: begin
          if (cnt == HALF_M1) begin
            if (rxd_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              cnt     <= '0;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        // LSB arrives first, so shifting in at the MSB leaves bit 0 at the LSB.
        DATA: begin
          if (cnt == DIV_M1) begin
            cnt     <= '0;
            shift   <= {rxd_s, shift[UART_DATA_W-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        // Returning to IDLE at mid-stop-bit leaves half a bit of slack for
        // the next start edge, which absorbs baud mismatch.
        STOP: begin
          if (cnt == DIV_M1) begin
            cnt <= '0;
            if (rxd_s) begin
              state <= IDLE;
              if (!o_valid || i_ready) begin
                o_data  <= shift;
                o_valid <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
              end
            end else begin
              o_frame_err <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: begin
          state <= WAIT_HIGH;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte
//   Directed plus randomized bench for uart_rx_byte. The receiver runs with
//   a reduced divisor so the whole run stays short; all expected timing is
//   derived from the divisor. The reference model works at frame level: a
//   queue of bytes that should reach the consumer, plus expected pulse counts
//   and the cycle at which each frame should complete.
`timescale 1ns / 1ps
module tb_uart_rx_byte;
  import uart_pkg::*;

  localparam int DIV = 116;
  localparam int HALF = DIV / 2;
  // From the first clock edge that sees the pin fall to the edge after which
  // the result is visible: 2 sync flops, half a bit, 9 whole bits.
  localparam int LAT = 2 + HALF + 9 * DIV;
  localparam int DIV_FAST = 111;
  localparam int DIV_SLOW = 121;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rxd = 1'b1;
  logic i_ready = 1'b0;
  logic [UART_DATA_W-1:0] o_data;
  logic o_valid;
  logic o_frame_err;
  logic o_overrun;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int pin_edge = 0;

  logic [7:0] xfer_q[$];
  logic [7:0] exp_q[$];
  int fe_cnt, ov_cnt, fe_cyc, ov_cyc, valid_rise, valid_cycles;
  logic valid_d = 1'b0;

  uart_rx_byte #(.CLK_DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rxd   (uart_rxd),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the DUT mid-cycle: transfers, pulses and o_valid history.
  always @(negedge clk) begin
    if (o_valid && i_ready) xfer_q.push_back(o_data);
    if (o_frame_err) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (o_overrun) begin
      ov_cnt++;
      ov_cyc = cyc;
    end
    if (o_valid && !valid_d && valid_rise < 0) valid_rise = cyc;
    if (o_valid) valid_cycles++;
    valid_d = o_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearCounters();
    xfer_q.delete();
    fe_cnt = 0;
    ov_cnt = 0;
    fe_cyc = -1;
    ov_cyc = -1;
    valid_rise = -1;
    valid_cycles = 0;
  endtask

  // Drive one 8N1 frame, LSB first. Must be called #1 after a clock edge;
  // leaves the line at the stop level.
  task automatic applyStimulus(input logic [7:0] data, input int bit_cycles,
                               input logic stop_level);
    logic [9:0] frame;
    frame = {stop_level, data, 1'b0};
    pin_edge = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      uart_rxd = frame[i];
      repeat (bit_cycles) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int e;
    int pin2;
    logic v_after;
    logic [7:0] d_after;
    logic [7:0] b;
    int bc;

    $display("[TB] start, CLK_DIV=%0d", DIV);
    clearCounters();
    idle(4);
    checkOutput("reset_data", o_data, 32'h00);
    checkOutput("reset_valid", o_valid, 32'd0);
    checkOutput("reset_frame_err", o_frame_err, 32'd0);
    checkOutput("reset_overrun", o_overrun, 32'd0);
    rst_n = 1'b1;
    idle(10);

    // Single byte with the consumer always ready.
    $display("[TB] single byte");
    i_ready = 1'b1;
    clearCounters();
    applyStimulus(8'hA5, DIV, 1'b1);
    idle(50);
    checkOutput("single_count", xfer_q.size(), 32'd1);
    checkOutput("single_data", xfer_q.size() > 0 ? xfer_q[0] : 8'hxx, 32'hA5);
    checkOutput("single_latency", valid_rise, pin_edge + LAT);
    checkOutput("single_valid_width", valid_cycles, 32'd1);
    checkOutput("single_frame_err", fe_cnt, 32'd0);
    checkOutput("single_overrun", ov_cnt, 32'd0);

    // Two back-to-back frames with no consumer: the second one overruns.
    $display("[TB] backpressure");
    i_ready = 1'b0;
    clearCounters();
    applyStimulus(8'h3C, DIV, 1'b1);
    applyStimulus(8'hC3, DIV, 1'b1);
    pin2 = pin_edge;
    idle(20);
    checkOutput("bp_valid", o_valid, 32'd1);
    checkOutput("bp_data", o_data, 32'h3C);
    checkOutput("bp_overrun_count", ov_cnt, 32'd1);
    checkOutput("bp_overrun_cycle", ov_cyc, pin2 + LAT);
    checkOutput("bp_no_xfer", xfer_q.size(), 32'd0);
    i_ready = 1'b1;
    idle(1);
    i_ready = 1'b0;
    idle(2);
    checkOutput("bp_drain_count", xfer_q.size(), 32'd1);
    checkOutput("bp_drain_data", xfer_q.size() > 0 ? xfer_q[0] : 8'hxx, 32'h3C);
    checkOutput("bp_valid_drop", o_valid, 32'd0);

    // Accept the held byte on exactly the cycle the next one completes.
    $display("[TB] accept and complete together");
    clearCounters();
    applyStimulus(8'h11, DIV, 1'b1);
    idle(40);
    e = cyc + 1 + LAT;
    v_after = 1'b0;
    d_after = 8'h00;
    fork
      applyStimulus(8'h22, DIV, 1'b1);
      begin
        repeat (e - 1 - cyc) @(posedge clk);
        #1;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        v_after = o_valid;
        d_after = o_data;
      end
    join
    idle(10);
    checkOutput("sim_xfer_count", xfer_q.size(), 32'd1);
    checkOutput("sim_xfer_data", xfer_q.size() > 0 ? xfer_q[0] : 8'hxx, 32'h11);
    checkOutput("sim_next_valid", v_after, 32'd1);
    checkOutput("sim_next_data", d_after, 32'h22);
    checkOutput("sim_overrun", ov_cnt, 32'd0);
    i_ready = 1'b1;
    idle(3);
    checkOutput("sim_drain_data", xfer_q.size() > 1 ? xfer_q[1] : 8'hxx, 32'h22);

    // Stop bit low, then a long break: one error, nothing delivered.
    $display("[TB] framing error");
    clearCounters();
    applyStimulus(8'h55, DIV, 1'b0);
    idle(3 * DIV);
    checkOutput("fe_count", fe_cnt, 32'd1);
    checkOutput("fe_cycle", fe_cyc, pin_edge + LAT);
    checkOutput("fe_no_xfer", xfer_q.size(), 32'd0);
    checkOutput("fe_no_valid", valid_cycles, 32'd0);
    uart_rxd = 1'b1;
    idle(2 * DIV);
    applyStimulus(8'h0F, DIV, 1'b1);
    idle(50);
    checkOutput("fe_recover_count", xfer_q.size(), 32'd1);
    checkOutput("fe_recover_data", xfer_q.size() > 0 ? xfer_q[0] : 8'hxx, 32'h0F);
    checkOutput("fe_recover_no_err", fe_cnt, 32'd1);

    // A low pulse shorter than half a bit is rejected.
    $display("[TB] glitch");
    clearCounters();
    uart_rxd = 1'b0;
    idle(30);
    uart_rxd = 1'b1;
    idle(12 * DIV);
    checkOutput("glitch_no_xfer", xfer_q.size(), 32'd0);
    checkOutput("glitch_no_valid", valid_cycles, 32'd0);
    checkOutput("glitch_frame_err", fe_cnt, 32'd0);

    // Reset in the middle of a frame, released while the line is low.
    $display("[TB] reset mid-frame");
    clearCounters();
    uart_rxd = 1'b0;
    idle(2 * DIV + 30);
    rst_n = 1'b0;
    idle(3);
    checkOutput("rst_mid_valid", o_valid, 32'd0);
    rst_n = 1'b1;
    idle(2 * DIV);
    uart_rxd = 1'b1;
    idle(2 * DIV);
    applyStimulus(8'h81, DIV, 1'b1);
    idle(12 * DIV);
    checkOutput("rst_count", xfer_q.size(), 32'd1);
    checkOutput("rst_data", xfer_q.size() > 0 ? xfer_q[0] : 8'hxx, 32'h81);
    checkOutput("rst_frame_err", fe_cnt, 32'd0);
    checkOutput("rst_overrun", ov_cnt, 32'd0);

    // Sender about 4% slow and 4% fast.
    $display("[TB] baud tolerance");
    clearCounters();
    applyStimulus(8'h96, DIV_SLOW, 1'b1);
    idle(200);
    applyStimulus(8'h96, DIV_FAST, 1'b1);
    idle(200);
    checkOutput("baud_count", xfer_q.size(), 32'd2);
    checkOutput("baud_slow", xfer_q.size() > 0 ? xfer_q[0] : 8'hxx, 32'h96);
    checkOutput("baud_fast", xfer_q.size() > 1 ? xfer_q[1] : 8'hxx, 32'h96);
    checkOutput("baud_frame_err", fe_cnt, 32'd0);

    // Random bytes, random small baud error, random idle gaps.
    $display("[TB] random frames");
    clearCounters();
    exp_q.delete();
    for (int n = 0; n < 6; n++) begin
      b = 8'($urandom);
      bc = DIV - 3 + int'($urandom_range(0, 6));
      exp_q.push_back(b);
      applyStimulus(b, bc, 1'b1);
      idle(int'($urandom_range(1, 150)));
    end
    idle(50);
    checkOutput("rand_count", xfer_q.size(), exp_q.size());
    for (int n = 0; n < 6; n++) begin
      checkOutput($sformatf("rand_byte%0d", n),
                  n < xfer_q.size() ? xfer_q[n] : 8'hxx, exp_q[n]);
    end
    checkOutput("rand_frame_err", fe_cnt, 32'd0);
    checkOutput("rand_overrun", ov_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

UART receiver that complements the design's existing 115200-baud 8N1 transmitter on `uart_txd`. It runs in the 133.33 MHz `clk_133MHz_210` domain and deserialises an asynchronous `uart_rxd` pin into bytes. Each byte is held in a one-entry buffer and handed to a consumer, such as a mode/command decoder, over a valid/ready handshake. Framing errors and overruns are reported as single-cycle pulses.

## Interface
- `CLK_DIV`, default 1157: clock cycles per bit (133 333 333 / 115 200). Legal range is ≥ 4 and < 2^16.
- `clk` in 1: 133.33 MHz system clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `uart_rxd` in 1: asynchronous serial line; idles high.
- `o_data` out 8: received byte, LSB-first reassembled; stable while `o_valid`=1.
- `o_valid` out 1: buffer holds an unconsumed byte.
- `i_ready` in 1: consumer accepts; transfer occurs on a cycle with `o_valid` && `i_ready`.
- `o_frame_err` out 1: 1-cycle pulse when the stop bit samples 0.
- `o_overrun` out 1: 1-cycle pulse when a good byte is dropped because the buffer is full.

## Operation
- Input goes through a 2-flop synchronizer. Sync flops and the previous-value flop reset to 1.
- Let `HALF` = `CLK_DIV`/2 (integer division). The bit counter is `cnt`, 16 bits, reset to 0.
- The state machine has five states:
  - **WAIT_HIGH** (reset state): go to IDLE on the first cycle the synchronized line is 1. This prevents a false start when reset is released mid-frame or during a break.
  - **IDLE**: on a synchronized falling edge (prev=1, cur=0), go to START with `cnt`=0.
  - **START**: when `cnt`==`HALF`-1, sample the line.
    - If it is 1, treat it as a glitch and return to IDLE with no flag.
    - If it is 0, go to DATA with `cnt`=0 and bit index 0.
  - **DATA**: when `cnt`==`CLK_DIV`-1, shift the sample into the shift register MSB, so bit 0 ends at LSB, and reset `cnt`. After the 8th sample, go to STOP.
  - **STOP**: when `cnt`==`CLK_DIV`-1, sample the line.
    - If it is 1, complete the byte and go to IDLE. IDLE is re-entered at mid-stop-bit, which tolerates about ±4% baud mismatch.
    - If it is 0, pulse `o_frame_err`, discard the byte, and go to WAIT_HIGH.
- Buffer behaviour on byte completion:
  - If `o_valid`=0, or `o_valid`&&`i_ready` in the same cycle: load `o_data` and set `o_valid` next cycle.
  - Otherwise: pulse `o_overrun`, drop the new byte, and keep the old byte and `o_valid`.
- `i_ready` with `o_valid`=0 has no effect. `o_valid` clears the cycle after a transfer unless a new byte loads in the same cycle.
- Reset values: `o_data`=8'h00, `o_valid`=0, `o_frame_err`=0, `o_overrun`=0, state=WAIT_HIGH. A mid-frame reset aborts the frame with no flags.

## Timing
- Define t0 as the first cycle the synchronized line reads 0, which is 2 cycles after the pin edge.
  - Start sample: t0+`HALF`-1.
  - Data bit k (k=0..7): t0+`HALF`-1+(k+1)·`CLK_DIV`.
  - Stop sample: t0+`HALF`-1+9·`CLK_DIV`.
- `o_valid`, `o_frame_err` and `o_overrun` assert the cycle after the stop sample.
  - With default `CLK_DIV`: stop sample at t0+10990; `o_valid` at t0+10991, which is pin edge + 10993.
- Back-to-back frames with no idle gap are received without loss, because the next falling edge arrives ≥ `HALF` cycles after IDLE is entered.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (WAIT_HIGH, IDLE, START, DATA, STOP);
  - constant `B115K2`=1157, shared with the transmitter;
  - constant `UART_DATA_W`=8.
- One sub-module, `uart_rx_sync`: the 2-flop synchronizer plus prev flop, producing `rxd_s` and `fall`. It resets to 1.
- The rest (FSM, counter, shift register, output buffer) lives in `uart_rx_byte`.

## Test plan
- **Single byte**: send 0xA5 at exactly 1157 clk/bit, `i_ready`=1.
  - Expect `o_data`=0xA5 with `o_valid` high for 1 cycle at pin edge + 10993, and no flags.
- **Backpressure/overrun**: send 0x3C then 0xC3 back-to-back with `i_ready`=0.
  - Expect `o_data` to stay 0x3C with `o_valid`=1, and `o_overrun` to pulse once at the second stop.
  - Then raise `i_ready`: 0x3C transfers and `o_valid` drops.
- **Simultaneous accept and complete**: hold 0x11 unconsumed; assert `i_ready` exactly on the cycle 0x22 completes.
  - Expect 0x11 to transfer, `o_data`=0x22 next cycle, `o_valid` to stay 1, and no overrun.
- **Framing error**: send 0x55 with stop bit 0, then hold the line low for 3 bit times.
  - Expect a single `o_frame_err` pulse, no `o_valid`, and no new start until the line returns high.
  - A following 0x0F is then received correctly.
- **Glitch and reset**:
  - A 300-cycle low pulse on an idle line produces no output.
  - Asserting `rst_n`=0 mid-frame, releasing it while the line is low, then sending 0x81 must yield exactly one byte, 0x81.
- **Baud tolerance**: send 0x96 at 1110 and at 1204 clk/bit.
  - Expect both received correctly.
